// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the main control FSM and the multiply/divide unit.
// Handshake: start is a one-cycle request honoured only while busy = 0; op/a_in/b_in are
// captured on that same edge. done is a one-cycle pulse during which hi/lo/div_zero are final.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes)
// producing Hi/Lo for the multicycle MIPS datapath.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus,
  output logic [2:0] state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MULT    = 3'd1,
    DIV     = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] prod;
  logic               q_m1;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic [WIDTH:0]     upper_ext;
  logic [WIDTH:0]     mcand_ext;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last_step;

  // Booth step: upper half widened by one bit so b = -2^(W-1) cases keep their sign.
  always_comb begin
    upper_ext = {prod[2*WIDTH-1], prod[2*WIDTH-1:WIDTH]};
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_sum = upper_ext;
    case ({prod[0], q_m1})
      2'b01:   booth_sum = upper_ext + mcand_ext;
      2'b10:   booth_sum = upper_ext - mcand_ext;
      default: booth_sum = upper_ext;
    endcase
  end

  // Restoring step: trial[WIDTH] set means the shifted remainder was below the divisor.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, dvsr};
    abs_a     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    abs_b     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
    last_step = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      prod   <= '0;
      q_m1   <= 1'b0;
      mcand  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            count  <= '0;
            dz_r   <= 1'b0;
            busy_r <= 1'b1;
            if (!bus.op) begin
              prod  <= {{WIDTH{1'b0}}, bus.a_in};
              q_m1  <= 1'b0;
              mcand <= bus.b_in;
              state <= MULT;
            end else if (bus.b_in == '0) begin
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              rem    <= '0;
              quo    <= abs_a;
              dvsr   <= abs_b;
              sign_a <= bus.a_in[WIDTH-1];
              sign_b <= bus.b_in[WIDTH-1];
              state  <= DIV;
            end
          end
        end
        MULT: begin
          prod  <= {booth_sum[WIDTH:1], booth_sum[0], prod[WIDTH-1:1]};
          q_m1  <= prod[0];
          count <= count + 1'b1;
          if (last_step) begin
            hi_r   <= booth_sum[WIDTH:1];
            lo_r   <= {booth_sum[0], prod[WIDTH-1:1]};
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          if (trial[WIDTH]) begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          count <= count + 1'b1;
          if (last_step) state <= DIV_FIX;
        end
        DIV_FIX: begin
          // Truncating division: quotient sign from operand signs, remainder follows dividend.
          lo_r   <= (sign_a ^ sign_b) ? -quo : quo;
          hi_r   <= sign_a ? -rem : rem;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign state_dbg    = state;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, protocol sequences, and
// random operations scored against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: signed 64-bit arithmetic, truncating division
  function automatic void ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 inout logic [W-1:0] h, inout logic [W-1:0] l,
                                 output logic dz, output int cyc);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!o) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
      cyc = 33;
    end else if (b == '0) begin
      dz = 1'b1;
      cyc = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
      cyc = 34;
    end
  endfunction

  // driver: issues one op from an IDLE cycle, returns in the first IDLE cycle after DONE
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch,
                        output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz,
                        output logic dz1, output int dcyc, output int busy_low,
                        output int hl_moved);
    int c;
    bit seen;
    logic [W-1:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    rh = '0; rl = '0; rdz = 1'b0;
    bus.start = 1'b1; bus.op = o; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    dz1 = bus.div_zero;
    c = 1; seen = 0; busy_low = 0; hl_moved = 0; dcyc = -1;
    while (!seen && c < 100) begin
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        seen = 1; dcyc = c; rh = bus.hi; rl = bus.lo; rdz = bus.div_zero;
      end else begin
        if (bus.hi !== h0 || bus.lo !== l0) hl_moved++;
        if (c == glitch) begin
          bus.start = 1'b1; bus.op = 1'b1; bus.a_in = $urandom; bus.b_in = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        c++;
      end
    end
    @(negedge clk);
    check("post_done_idle", {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  task automatic do_vec(input string tag, input vec_t v, input int glitch);
    logic [W-1:0] rh, rl;
    logic rdz, dz1;
    int dcyc, busy_low, hl_moved;
    run_op(v.op, v.a, v.b, glitch, rh, rl, rdz, dz1, dcyc, busy_low, hl_moved);
    check({tag, ".hi"}, 64'(rh), 64'(v.hi));
    check({tag, ".lo"}, 64'(rl), 64'(v.lo));
    check({tag, ".div_zero"}, 64'(rdz), 64'(v.dz));
    check({tag, ".div_zero_c1"}, 64'(dz1), 64'(v.dz));
    check({tag, ".done_cycle"}, 64'(dcyc), 64'(v.cyc));
    check({tag, ".busy_gaps"}, 64'(busy_low), 64'd0);
    check({tag, ".hilo_early"}, 64'(hl_moved), 64'd0);
    model_hi = v.hi;
    model_lo = v.lo;
  endtask

  vec_t table_v[11];

  initial begin
    vec_t v;
    int done_seen;
    table_v[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    table_v[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    table_v[2]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    table_v[3]  = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
    table_v[4]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    table_v[5]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    table_v[6]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    table_v[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 34};
    table_v[8]  = '{1'b1, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0, 34};
    table_v[9]  = '{1'b1, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 1};
    table_v[10] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.hi", 64'(bus.hi), 64'd0);
    check("reset.lo", 64'(bus.lo), 64'd0);
    check("reset.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_vec($sformatf("tab%0d", i), table_v[i], 0);
      if (table_v[i].dz) begin
        repeat (3) @(negedge clk);
        check("div_zero_sticky", 64'(bus.div_zero), 64'd1);
      end
    end

    // start pulsed mid-mult must be ignored
    v.op = 1'b0; v.a = 32'h00001234; v.b = 32'hFFFFFFAA;
    v.hi = model_hi; v.lo = model_lo;
    ref_op(v.op, v.a, v.b, v.hi, v.lo, v.dz, v.cyc);
    do_vec("glitch_start", v, 10);

    // reset in cycle 15 of a divide aborts with no result and no done
    bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'd1000; bus.b_in = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.hi", 64'(bus.hi), 64'd0);
    check("abort.lo", 64'(bus.lo), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    model_hi = '0;
    model_lo = '0;

    // random operations against the model
    for (int n = 0; n < 40; n++) begin
      v.op = 1'($urandom_range(0, 1));
      v.a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      case ($urandom_range(0, 7))
        0:       v.b = '0;
        1, 2:    v.b = 32'($urandom_range(0, 40)) - 32'd20;
        default: v.b = $urandom;
      endcase
      v.hi = model_hi; v.lo = model_lo;
      ref_op(v.op, v.a, v.b, v.hi, v.lo, v.dz, v.cyc);
      do_vec($sformatf("rnd%0d", n), v, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential multiply/divide unit for the multicycle MIPS datapath, executing mult and div.
- Driven directly by the main control FSM, which asserts start with op and holds in a wait state until done.
- Operands come from the A/B operand registers; results go to the Hi/Lo registers read by mfhi/mflo.
- div_zero feeds the control unit's exception path.

Parameters:
WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = mult (signed), 1 = div (signed); sampled with start
a_in  input  WIDTH  multiplicand / dividend (rs)
b_in  input  WIDTH  multiplier / divisor (rt)
hi  output  WIDTH  mult: upper product; div: remainder
lo  output  WIDTH  mult: lower product; div: quotient
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; hi/lo valid in that cycle
div_zero  output  1  div with b_in = 0; sticky until next accepted start

Behaviour:
- Reset: clk and reset as decided (asynchronous, active-high).
  - State goes to IDLE; hi, lo, counter and internal registers are cleared to 0.
  - busy = 0, done = 0, div_zero = 0.
  - Reset mid-operation aborts the operation; no partial result is ever written to hi/lo.
- States: IDLE, MULT, DIV, DIV_FIX, DONE.
- Cycle numbering: cycle 0 is the cycle in which start = 1 is sampled in IDLE.
- IDLE, start = 1:
  - Latch a_in, b_in and op; clear div_zero; counter = 0.
  - op = 0: go to MULT.
  - op = 1 and b_in != 0: go to DIV.
  - op = 1 and b_in == 0: go to DONE with div_zero = 1; hi/lo keep their old values.
  - start = 0: stay in IDLE.
- MULT (radix-2 Booth):
  - Working register {P[2W-1:0], q-1}, initialised to {0, a, 0}.
  - Each cycle: inspect {P[0], q-1}.
    - 01: add b to the upper half.
    - 10: subtract b from the upper half.
    - Then arithmetic shift right by 1.
  - Upper-half add/subtract uses W+1 bits so the sign is preserved.
  - After WIDTH steps (cycles 1..32): write hi/lo from P and go to DONE.
  - done = 1 in cycle 33.
- DIV (restoring, on magnitudes):
  - Initialise with |a|, |b| and the signs latched in IDLE.
  - One quotient bit per cycle over cycles 1..32, then go to DIV_FIX.
- DIV_FIX (cycle 33):
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Write lo = quotient, hi = remainder; go to DONE.
  - done = 1 in cycle 34.
- Special case: a = 0x80000000, b = -1 gives lo = 0x80000000, hi = 0 (wraps; no overflow flag).
- DONE:
  - done = 1 for exactly one cycle, then unconditionally go to IDLE.
  - busy = 1 in DONE.
- Outputs:
  - start while busy is ignored; operands are not re-latched.
  - hi and lo hold their value between operations and change only at the final write edge.
  - Operand inputs may change after cycle 0 without affecting the result.
  - Back-to-back operation: the earliest next accepted start is the first IDLE cycle after DONE.

Test Plan:
- Signed mult: start, op=0, a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high only in cycle 33; busy high in cycles 1–33.
- Extreme mult: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; then a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- Signed div: op=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in cycle 34; a=100, b=7 -> lo=14, hi=2.
- Divide by zero, with hi=0x11, lo=0x22 preloaded by a prior op: a=5, b=0 -> done and div_zero in cycle 1, hi/lo unchanged; div_zero stays 1 until the next start, then clears.
- Overflow div: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Protocol:
  - start pulsed in cycle 10 of a mult -> ignored; result equals the original operands' product.
  - reset asserted in cycle 15 of a div -> immediately busy=0 and hi=lo=0; no done pulse follows.
